// File: rtl/tff_counter_pkg.sv
// Shared constants and the parameter-legality check for the toggle-flop counter.
package tff_counter_pkg;

   // Boundary behaviour selectors for the SATURATE parameter.
   localparam int MODE_WRAP = 0;
   localparam int MODE_SAT  = 1;

   // Returns 1 when the parameter combination is legal:
   // width 2..32, max_val 1..2**width-1, saturate one of the two modes.
   function automatic bit params_legal(input int width,
                                       input int unsigned max_val,
                                       input int saturate);
      longint unsigned limit;
      if (width < 2 || width > 32) return 1'b0;
      limit = (64'd1 << width) - 64'd1;
      if (max_val < 1) return 1'b0;
      if (64'(max_val) > limit) return 1'b0;
      if (saturate != MODE_WRAP && saturate != MODE_SAT) return 1'b0;
      return 1'b1;
   endfunction

endpackage

// File: rtl/tff_counter_cell.sv
// One-bit toggle flop with synchronous active-high reset.
module tff_cell (
   input  logic clk,
   input  logic rst,
   input  logic t,
   output logic q
);

   // Flip the stored bit whenever the toggle enable is high.
   always_ff @(posedge clk) begin
      if (rst)
         q <= 1'b0;
      else if (t)
         q <= ~q;
   end

endmodule

// File: rtl/tff_counter.sv
// Up/down counter built from per-bit toggle flops, with load clamp,
// wrap or saturate at the bound, a terminal-count pulse and a sticky
// overflow flag.
module tff_counter
   import tff_counter_pkg::*;
#(
   parameter int          WIDTH    = 8,
   parameter int unsigned MAX_VAL  = (2**WIDTH) - 1,
   parameter int          SATURATE = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   input  logic             ovf_clr,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qb,
   output logic             tc,
   output logic             ovf
);

   // An illegal MAX_VAL falls back to the full binary range so the
   // datapath stays well defined.
   localparam bit               PARAMS_OK = params_legal(WIDTH, MAX_VAL, SATURATE);
   localparam logic [WIDTH-1:0] MAX_Q     = PARAMS_OK ? MAX_VAL[WIDTH-1:0] : {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam bit               SAT_MODE  = (SATURATE == MODE_SAT);

   logic [WIDTH-1:0] q_next;
   logic [WIDTH-1:0] t_vec;
   logic             bnd;

   // Boundary event: an enabled count step that would leave [0, MAX_Q].
   // When MAX_Q is all-ones the wrap values coincide with plain modulo
   // arithmetic, so no special casing is needed.
   always_comb begin
      bnd = en & ~clr & ~load & (up ? (q == MAX_Q) : (q == '0));
   end

   // Next count value in priority order clr > load > en > hold (rst is
   // applied inside the cells and overrides everything).
   always_comb begin
      q_next = q;
      if (clr)
         q_next = '0;
      else if (load)
         q_next = (din > MAX_Q) ? MAX_Q : din;
      else if (en) begin
         if (bnd)
            q_next = SAT_MODE ? q : (up ? '0 : MAX_Q);
         else
            q_next = up ? (q + ONE) : (q - ONE);
      end
   end

   // Each bit toggles exactly when its next value differs from the current one.
   always_comb begin
      t_vec = q_next ^ q;
   end

   genvar i;
   generate
      for (i = 0; i < WIDTH; i++) begin : g_cell
         tff_cell u_cell (
            .clk (clk),
            .rst (rst),
            .t   (t_vec[i]),
            .q   (q[i])
         );
      end
   endgenerate

   assign qb = ~q;

   // tc pulses for the one cycle after each boundary event.
   always_ff @(posedge clk) begin
      if (rst)
         tc <= 1'b0;
      else
         tc <= bnd;
   end

   // Sticky overflow: a boundary event wins over a simultaneous clear.
   always_ff @(posedge clk) begin
      if (rst)
         ovf <= 1'b0;
      else if (bnd)
         ovf <= 1'b1;
      else if (ovf_clr)
         ovf <= 1'b0;
   end

endmodule

// File: tb/tb_tff_counter.sv
// Directed bench for tff_counter: 4-bit wrap (max 9), 4-bit saturate
// (max 9) and 8-bit full-range instances.
module tb_tff_counter;

   int total = 0;
   int bad   = 0;

   // clock
   logic clk = 1'b0;
   always #5 clk = ~clk;

   // wrap instance, WIDTH=4 MAX_VAL=9
   logic       rst_a = 1'b0, en_a = 1'b0, up_a = 1'b0, clr_a = 1'b0, load_a = 1'b0, ovf_clr_a = 1'b0;
   logic [3:0] din_a = '0, q_a, qb_a;
   logic       tc_a, ovf_a;

   // saturate instance, WIDTH=4 MAX_VAL=9
   logic       rst_s = 1'b0, en_s = 1'b0, up_s = 1'b0, clr_s = 1'b0, load_s = 1'b0, ovf_clr_s = 1'b0;
   logic [3:0] din_s = '0, q_s, qb_s;
   logic       tc_s, ovf_s;

   // full-range instance, WIDTH=8 default MAX_VAL
   logic       rst_w = 1'b0, en_w = 1'b0, up_w = 1'b0, clr_w = 1'b0, load_w = 1'b0, ovf_clr_w = 1'b0;
   logic [7:0] din_w = '0, q_w, qb_w;
   logic       tc_w, ovf_w;

   tff_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0)) dut_a (
      .clk(clk), .rst(rst_a), .en(en_a), .up(up_a), .clr(clr_a), .load(load_a),
      .din(din_a), .ovf_clr(ovf_clr_a), .q(q_a), .qb(qb_a), .tc(tc_a), .ovf(ovf_a));

   tff_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1)) dut_s (
      .clk(clk), .rst(rst_s), .en(en_s), .up(up_s), .clr(clr_s), .load(load_s),
      .din(din_s), .ovf_clr(ovf_clr_s), .q(q_s), .qb(qb_s), .tc(tc_s), .ovf(ovf_s));

   tff_counter #(.WIDTH(8)) dut_w (
      .clk(clk), .rst(rst_w), .en(en_w), .up(up_w), .clr(clr_w), .load(load_w),
      .din(din_w), .ovf_clr(ovf_clr_w), .q(q_w), .qb(qb_w), .tc(tc_w), .ovf(ovf_w));

   // advance one rising edge, then settle before sampling/driving
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_a = 1'b1; rst_s = 1'b1; rst_w = 1'b1;
      step();
      rst_a = 1'b0; rst_s = 1'b0; rst_w = 1'b0;
      total++; if (q_a !== 4'd0)   begin bad++; $display("FAIL reset_q got=%0d exp=0", q_a); end
      total++; if (qb_a !== 4'hF)  begin bad++; $display("FAIL reset_qb got=%h exp=f", qb_a); end
      total++; if (tc_a !== 1'b0)  begin bad++; $display("FAIL reset_tc got=%b exp=0", tc_a); end
      total++; if (ovf_a !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf_a); end
      total++; if (q_s !== 4'd0)   begin bad++; $display("FAIL reset_q_sat got=%0d exp=0", q_s); end
      total++; if (q_w !== 8'd0)   begin bad++; $display("FAIL reset_q_w8 got=%0d exp=0", q_w); end
   endtask

   // 12 up-counts from 0: 1..9,0,1,2; tc only when 0 appears; ovf from then on
   task automatic test_count_up();
      logic [3:0] exp_q [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
      logic       exp_tc[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
      logic       exp_ov[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
      en_a = 1'b1; up_a = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step();
         total++; if (q_a !== exp_q[i])    begin bad++; $display("FAIL up_q[%0d] got=%0d exp=%0d", i, q_a, exp_q[i]); end
         total++; if (tc_a !== exp_tc[i])  begin bad++; $display("FAIL up_tc[%0d] got=%b exp=%b", i, tc_a, exp_tc[i]); end
         total++; if (ovf_a !== exp_ov[i]) begin bad++; $display("FAIL up_ovf[%0d] got=%b exp=%b", i, ovf_a, exp_ov[i]); end
      end
      en_a = 1'b0;
   endtask

   // load clamp, then load beating en at q=9 with no boundary event
   task automatic test_load_clamp();
      load_a = 1'b1; din_a = 4'd13;
      step();
      total++; if (q_a !== 4'd9)   begin bad++; $display("FAIL clamp_q got=%0d exp=9", q_a); end
      total++; if (tc_a !== 1'b0)  begin bad++; $display("FAIL clamp_tc got=%b exp=0", tc_a); end
      din_a = 4'd5; en_a = 1'b1; up_a = 1'b1;
      step();
      load_a = 1'b0; en_a = 1'b0;
      total++; if (q_a !== 4'd5)   begin bad++; $display("FAIL load_wins_q got=%0d exp=5", q_a); end
      total++; if (tc_a !== 1'b0)  begin bad++; $display("FAIL load_wins_tc got=%b exp=0", tc_a); end
      total++; if (ovf_a !== 1'b1) begin bad++; $display("FAIL load_keeps_ovf got=%b exp=1", ovf_a); end
      step();
      total++; if (q_a !== 4'd5)   begin bad++; $display("FAIL hold_q got=%0d exp=5", q_a); end
   endtask

   // ovf set beats ovf_clr; ovf_clr alone clears
   task automatic test_ovf_clr();
      ovf_clr_a = 1'b1;
      step();
      total++; if (ovf_a !== 1'b0) begin bad++; $display("FAIL ovf_clr_pre got=%b exp=0", ovf_a); end
      ovf_clr_a = 1'b0; load_a = 1'b1; din_a = 4'd9;
      step();
      load_a = 1'b0; en_a = 1'b1; up_a = 1'b1; ovf_clr_a = 1'b1;
      step();
      total++; if (q_a !== 4'd0)   begin bad++; $display("FAIL setwins_q got=%0d exp=0", q_a); end
      total++; if (ovf_a !== 1'b1) begin bad++; $display("FAIL setwins_ovf got=%b exp=1", ovf_a); end
      total++; if (tc_a !== 1'b1)  begin bad++; $display("FAIL setwins_tc got=%b exp=1", tc_a); end
      en_a = 1'b0;
      step();
      ovf_clr_a = 1'b0;
      total++; if (ovf_a !== 1'b0) begin bad++; $display("FAIL clr_alone_ovf got=%b exp=0", ovf_a); end
      total++; if (tc_a !== 1'b0)  begin bad++; $display("FAIL clr_alone_tc got=%b exp=0", tc_a); end
      total++; if (q_a !== 4'd0)   begin bad++; $display("FAIL clr_alone_q got=%0d exp=0", q_a); end
   endtask

   // down-wrap from 0 to 9, then immediate direction change
   task automatic test_down_wrap();
      en_a = 1'b1; up_a = 1'b0;
      step();
      total++; if (q_a !== 4'd9)   begin bad++; $display("FAIL dn_wrap_q got=%0d exp=9", q_a); end
      total++; if (tc_a !== 1'b1)  begin bad++; $display("FAIL dn_wrap_tc got=%b exp=1", tc_a); end
      total++; if (ovf_a !== 1'b1) begin bad++; $display("FAIL dn_wrap_ovf got=%b exp=1", ovf_a); end
      step();
      total++; if (q_a !== 4'd8)   begin bad++; $display("FAIL dn_q got=%0d exp=8", q_a); end
      total++; if (tc_a !== 1'b0)  begin bad++; $display("FAIL dn_tc got=%b exp=0", tc_a); end
      up_a = 1'b1;
      step();
      total++; if (q_a !== 4'd9)   begin bad++; $display("FAIL dir_change_q got=%0d exp=9", q_a); end
      clr_a = 1'b1;
      step();
      clr_a = 1'b0;
      total++; if (q_a !== 4'd0)   begin bad++; $display("FAIL clr_q got=%0d exp=0", q_a); end
      total++; if (tc_a !== 1'b0)  begin bad++; $display("FAIL clr_tc got=%b exp=0", tc_a); end
      total++; if (ovf_a !== 1'b1) begin bad++; $display("FAIL clr_keeps_ovf got=%b exp=1", ovf_a); end
      en_a = 1'b0;
   endtask

   // reset during counting overrides clr/load/en, and a boundary cycle leaves no tc
   task automatic test_rst_override();
      load_a = 1'b1; din_a = 4'd5;
      step();
      load_a = 1'b0; en_a = 1'b1; up_a = 1'b1;
      step();
      total++; if (q_a !== 4'd6)   begin bad++; $display("FAIL pre_rst_q got=%0d exp=6", q_a); end
      rst_a = 1'b1; clr_a = 1'b1; load_a = 1'b1; din_a = 4'd3;
      step();
      rst_a = 1'b0; clr_a = 1'b0; load_a = 1'b0; en_a = 1'b0;
      total++; if (q_a !== 4'd0)   begin bad++; $display("FAIL rst_ovr_q got=%0d exp=0", q_a); end
      total++; if (qb_a !== 4'hF)  begin bad++; $display("FAIL rst_ovr_qb got=%h exp=f", qb_a); end
      total++; if (tc_a !== 1'b0)  begin bad++; $display("FAIL rst_ovr_tc got=%b exp=0", tc_a); end
      total++; if (ovf_a !== 1'b0) begin bad++; $display("FAIL rst_ovr_ovf got=%b exp=0", ovf_a); end
      load_a = 1'b1; din_a = 4'd9;
      step();
      load_a = 1'b0; rst_a = 1'b1; en_a = 1'b1; up_a = 1'b1;
      step();
      rst_a = 1'b0; en_a = 1'b0;
      total++; if (tc_a !== 1'b0)  begin bad++; $display("FAIL rst_bnd_tc got=%b exp=0", tc_a); end
      total++; if (ovf_a !== 1'b0) begin bad++; $display("FAIL rst_bnd_ovf got=%b exp=0", ovf_a); end
      step();
      total++; if (tc_a !== 1'b0)  begin bad++; $display("FAIL rst_residual_tc got=%b exp=0", tc_a); end
   endtask

   // saturate: load 2, down x4 -> 1,0,0,0 with tc on each hold
   task automatic test_saturate();
      logic [3:0] exp_q [4] = '{4'd1, 4'd0, 4'd0, 4'd0};
      logic       exp_tc[4] = '{0, 0, 1, 1};
      logic       exp_ov[4] = '{0, 0, 1, 1};
      load_s = 1'b1; din_s = 4'd2;
      step();
      load_s = 1'b0;
      total++; if (q_s !== 4'd2) begin bad++; $display("FAIL sat_load_q got=%0d exp=2", q_s); end
      en_s = 1'b1; up_s = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         total++; if (q_s !== exp_q[i])    begin bad++; $display("FAIL sat_q[%0d] got=%0d exp=%0d", i, q_s, exp_q[i]); end
         total++; if (tc_s !== exp_tc[i])  begin bad++; $display("FAIL sat_tc[%0d] got=%b exp=%b", i, tc_s, exp_tc[i]); end
         total++; if (ovf_s !== exp_ov[i]) begin bad++; $display("FAIL sat_ovf[%0d] got=%b exp=%b", i, ovf_s, exp_ov[i]); end
      end
      up_s = 1'b1;
      step();
      total++; if (q_s !== 4'd1)  begin bad++; $display("FAIL sat_up_q got=%0d exp=1", q_s); end
      total++; if (tc_s !== 1'b0) begin bad++; $display("FAIL sat_up_tc got=%b exp=0", tc_s); end
      en_s = 1'b0; load_s = 1'b1; din_s = 4'd9;
      step();
      load_s = 1'b0; en_s = 1'b1;
      step();
      en_s = 1'b0;
      total++; if (q_s !== 4'd9)  begin bad++; $display("FAIL sat_top_q got=%0d exp=9", q_s); end
      total++; if (tc_s !== 1'b1) begin bad++; $display("FAIL sat_top_tc got=%b exp=1", tc_s); end
   endtask

   // 8-bit full range: 255 -> 0 up, then 0 -> 255 down
   task automatic test_full_range();
      load_w = 1'b1; din_w = 8'd255;
      step();
      load_w = 1'b0; en_w = 1'b1; up_w = 1'b1;
      step();
      total++; if (q_w !== 8'd0)   begin bad++; $display("FAIL w8_up_q got=%0d exp=0", q_w); end
      total++; if (tc_w !== 1'b1)  begin bad++; $display("FAIL w8_up_tc got=%b exp=1", tc_w); end
      total++; if (ovf_w !== 1'b1) begin bad++; $display("FAIL w8_up_ovf got=%b exp=1", ovf_w); end
      up_w = 1'b0;
      step();
      total++; if (q_w !== 8'd255) begin bad++; $display("FAIL w8_dn_q got=%0d exp=255", q_w); end
      total++; if (tc_w !== 1'b1)  begin bad++; $display("FAIL w8_dn_tc got=%b exp=1", tc_w); end
      total++; if (qb_w !== 8'd0)  begin bad++; $display("FAIL w8_dn_qb got=%0d exp=0", qb_w); end
      step();
      en_w = 1'b0;
      total++; if (q_w !== 8'd254) begin bad++; $display("FAIL w8_dn2_q got=%0d exp=254", q_w); end
      total++; if (tc_w !== 1'b0)  begin bad++; $display("FAIL w8_dn2_tc got=%b exp=0", tc_w); end
   endtask

   initial begin
      #2;
      test_reset();
      test_count_up();
      test_load_clamp();
      test_ovf_clr();
      test_down_wrap();
      test_rst_override();
      test_saturate();
      test_full_range();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
